// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared Wishbone B4 definitions for the SRAM arbiter slice:
//   - CTI / BTE field widths and code points
//   - arbiter FSM state encoding (wb_arb_state_t)
//   - wb_cti_rewrite(): maps an owner CTI onto one the SRAM slave terminates on
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int WB_CTI_W = 3;
    localparam int WB_BTE_W = 2;

    localparam logic [WB_CTI_W-1:0] WB_CTI_CLASSIC      = 3'b000;
    localparam logic [WB_CTI_W-1:0] WB_CTI_CONSTANT     = 3'b001;
    localparam logic [WB_CTI_W-1:0] WB_CTI_INCREMENTING = 3'b010;
    localparam logic [WB_CTI_W-1:0] WB_CTI_END_OF_BURST = 3'b111;

    localparam logic [WB_BTE_W-1:0] WB_BTE_LINEAR = 2'b00;
    localparam logic [WB_BTE_W-1:0] WB_BTE_4BEAT  = 2'b01;
    localparam logic [WB_BTE_W-1:0] WB_BTE_8BEAT  = 2'b10;
    localparam logic [WB_BTE_W-1:0] WB_BTE_16BEAT = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_FLUSH = 2'd2
    } wb_arb_state_t;

    // Only incrementing bursts and explicit end-of-burst are passed through;
    // everything else becomes a single terminated beat so the slave never
    // waits for a follow-on beat that will not come.
    function automatic logic [WB_CTI_W-1:0] wb_cti_rewrite(input logic [WB_CTI_W-1:0] cti);
        if (cti == WB_CTI_INCREMENTING || cti == WB_CTI_END_OF_BURST)
            return cti;
        return WB_CTI_END_OF_BURST;
    endfunction

endpackage

// File: rtl/wb_arb_pick.sv
// -----------------------------------------------------------------------------
// wb_arb_pick
// Combinational N-way one-hot picker. Scans the request vector starting at
// index ptr_i and wrapping modulo N; the first requester found wins.
// A pointer of 0 gives fixed lowest-index priority.
// Ports:
//   req_i   [N-1:0]      request vector
//   ptr_i   [PTR_W-1:0]  search start index (must be < N)
//   grant_o [N-1:0]      one-hot winner, 0 when no request
// -----------------------------------------------------------------------------
module wb_arb_pick #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o
);

    logic             found;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            // One extra bit holds ptr+i before the modulo-N wrap.
            sum = {1'b0, ptr_i} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(N))
                sum = sum - (PTR_W+1)'(N);
            idx = sum[PTR_W-1:0];
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// wb_sram_arbiter
// Wishbone B4 N-to-1 arbiter sharing one sram_wb slave among several masters.
// A master owns the slave for a whole classic cycle or incrementing burst; the
// grant is released only after the end-of-burst ack, or after a short flush
// when the owner abandons its cycle. CTI is rewritten so the slave always sees
// a terminating transfer.
//
// Configuration macro: WB_ARB_ROUND_ROBIN_EN
//   defined   -> round-robin arbitration (pointer advances past each winner)
//   undefined -> fixed priority, lowest index wins
//
// Ports (N = OPTN_NUM_MASTERS):
//   i_wb_clk, i_wb_rst              clock, async active-high reset
//   i_wb_cyc/stb/we   [N]           per-master controls
//   i_wb_cti [3N], i_wb_bte [2N]    per-master burst info
//   i_wb_sel/addr/data              per-master select/address/write data
//   o_wb_ack [N]                    per-master ack (owner only)
//   o_wb_data                       read data broadcast to all masters
//   o_sl_*                          slave-side Wishbone outputs
//   i_sl_ack, i_sl_data             slave ack and read data
//   o_grant [N]                     one-hot current owner
// -----------------------------------------------------------------------------
module wb_sram_arbiter
    import wb_pkg::*;
#(
    parameter int OPTN_NUM_MASTERS   = 2,
    parameter int OPTN_WB_DATA_WIDTH = 16,
    parameter int OPTN_WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_SIZE       = OPTN_WB_DATA_WIDTH/8
) (
    input  logic                                       i_wb_clk,
    input  logic                                       i_wb_rst,
    input  logic [OPTN_NUM_MASTERS-1:0]                i_wb_cyc,
    input  logic [OPTN_NUM_MASTERS-1:0]                i_wb_stb,
    input  logic [OPTN_NUM_MASTERS-1:0]                i_wb_we,
    input  logic [OPTN_NUM_MASTERS*3-1:0]              i_wb_cti,
    input  logic [OPTN_NUM_MASTERS*2-1:0]              i_wb_bte,
    input  logic [OPTN_NUM_MASTERS*WB_DATA_SIZE-1:0]   i_wb_sel,
    input  logic [OPTN_NUM_MASTERS*OPTN_WB_ADDR_WIDTH-1:0] i_wb_addr,
    input  logic [OPTN_NUM_MASTERS*OPTN_WB_DATA_WIDTH-1:0] i_wb_data,
    output logic [OPTN_NUM_MASTERS-1:0]                o_wb_ack,
    output logic [OPTN_WB_DATA_WIDTH-1:0]              o_wb_data,
    output logic                                       o_sl_cyc,
    output logic                                       o_sl_stb,
    output logic                                       o_sl_we,
    output logic [2:0]                                 o_sl_cti,
    output logic [1:0]                                 o_sl_bte,
    output logic [WB_DATA_SIZE-1:0]                    o_sl_sel,
    output logic [OPTN_WB_ADDR_WIDTH-1:0]              o_sl_addr,
    output logic [OPTN_WB_DATA_WIDTH-1:0]              o_sl_data,
    input  logic                                       i_sl_ack,
    input  logic [OPTN_WB_DATA_WIDTH-1:0]              i_sl_data,
    output logic [OPTN_NUM_MASTERS-1:0]                o_grant
);

    localparam int N     = OPTN_NUM_MASTERS;
    localparam int DW    = OPTN_WB_DATA_WIDTH;
    localparam int AW    = OPTN_WB_ADDR_WIDTH;
    localparam int SW    = WB_DATA_SIZE;
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    wb_arb_state_t    state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [N-1:0]     req;
    logic [N-1:0]     pick;
    logic [PTR_W-1:0] ptr_sel;

    logic             own_cyc, own_stb, own_we;
    logic [2:0]       own_cti;
    logic [1:0]       own_bte;
    logic [SW-1:0]    own_sel;
    logic [AW-1:0]    own_addr;
    logic [DW-1:0]    own_data;

    assign req = i_wb_cyc & i_wb_stb;

    wb_arb_pick #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_sel),
        .grant_o (pick)
    );

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win_idx;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N; i++)
            if (pick[i])
                win_idx = PTR_W'(i);
    end

    // Next search starts just past the winner so it goes to the back of the line.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ARB_IDLE && |req)
            ptr_d = (win_idx == PTR_W'(N-1)) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end

    assign ptr_sel = ptr_q;
`else
    assign ptr_sel = '0;
`endif

    // AND-OR mux of the owner's signals; grant_q is one-hot or zero.
    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        own_we   = 1'b0;
        own_cti  = '0;
        own_bte  = '0;
        own_sel  = '0;
        own_addr = '0;
        own_data = '0;
        for (int i = 0; i < N; i++) begin
            own_cyc  = own_cyc | (grant_q[i] & i_wb_cyc[i]);
            own_stb  = own_stb | (grant_q[i] & i_wb_stb[i]);
            own_we   = own_we  | (grant_q[i] & i_wb_we[i]);
            own_cti  = own_cti  | ({3{grant_q[i]}}  & i_wb_cti[i*3 +: 3]);
            own_bte  = own_bte  | ({2{grant_q[i]}}  & i_wb_bte[i*2 +: 2]);
            own_sel  = own_sel  | ({SW{grant_q[i]}} & i_wb_sel[i*SW +: SW]);
            own_addr = own_addr | ({AW{grant_q[i]}} & i_wb_addr[i*AW +: AW]);
            own_data = own_data | ({DW{grant_q[i]}} & i_wb_data[i*DW +: DW]);
        end
    end

    // Slave side is only driven while a grant is live; IDLE and FLUSH present
    // a quiet bus with CTI at end-of-burst.
    always_comb begin
        o_sl_cyc  = 1'b0;
        o_sl_stb  = 1'b0;
        o_sl_we   = 1'b0;
        o_sl_cti  = WB_CTI_END_OF_BURST;
        o_sl_bte  = '0;
        o_sl_sel  = '0;
        o_sl_addr = '0;
        o_sl_data = '0;
        o_wb_ack  = '0;
        if (state_q == ARB_GRANT) begin
            o_sl_cyc  = own_cyc;
            o_sl_stb  = own_stb;
            o_sl_we   = own_we;
            o_sl_cti  = wb_cti_rewrite(own_cti);
            o_sl_bte  = own_bte;
            o_sl_sel  = own_sel;
            o_sl_addr = own_addr;
            o_sl_data = own_data;
            o_wb_ack  = grant_q & {N{i_sl_ack}};
        end
    end

    assign o_wb_data = i_sl_data;
    assign o_grant   = grant_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (|req) begin
                    grant_d = pick;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                // A terminating ack wins over an abandoned cycle in the same beat.
                if (i_sl_ack && o_sl_cti == WB_CTI_END_OF_BURST) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                end else if (!own_cyc) begin
                    state_d = ARB_FLUSH;
                    cnt_d   = 2'd3;
                end
            end
            ARB_FLUSH: begin
                // Give the slave up to three cycles to drain its pending beat.
                if (i_sl_ack || cnt_q <= 2'd1) begin
                    state_d = ARB_IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_sram_arbiter
// Directed bench for wb_sram_arbiter (N=2, 16-bit data). Each issued beat
// pushes its expected response onto the issuing master's queue; a monitor on
// the falling edge pops and compares whenever the arbiter acks a master.
// A small slave model acks every other cycle and returns 0xBEEF for address
// 0x10 and addr[15:0]^0x1234 otherwise.
// -----------------------------------------------------------------------------
module tb_wb_sram_arbiter;

    localparam int N  = 2;
    localparam int DW = 16;
    localparam int AW = 32;
    localparam int SW = 2;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          m_cyc  [N];
    logic          m_stb  [N];
    logic          m_we   [N];
    logic [2:0]    m_cti  [N];
    logic [AW-1:0] m_addr [N];
    logic [DW-1:0] m_data [N];

    logic [N-1:0]    wb_cyc, wb_stb, wb_we;
    logic [N*3-1:0]  wb_cti;
    logic [N*2-1:0]  wb_bte;
    logic [N*SW-1:0] wb_sel;
    logic [N*AW-1:0] wb_addr;
    logic [N*DW-1:0] wb_data;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign wb_cyc[g]              = m_cyc[g];
        assign wb_stb[g]              = m_stb[g];
        assign wb_we[g]               = m_we[g];
        assign wb_cti[g*3 +: 3]       = m_cti[g];
        assign wb_addr[g*AW +: AW]    = m_addr[g];
        assign wb_data[g*DW +: DW]    = m_data[g];
    end
    assign wb_bte = '0;
    assign wb_sel = '1;

    logic [N-1:0]  wb_ack, grant;
    logic [DW-1:0] wb_rdata;
    logic          sl_cyc, sl_stb, sl_we;
    logic [2:0]    sl_cti;
    logic [1:0]    sl_bte;
    logic [SW-1:0] sl_sel;
    logic [AW-1:0] sl_addr;
    logic [DW-1:0] sl_wdata;
    logic          sl_ack;
    logic [DW-1:0] sl_rdata;

    wb_sram_arbiter #(
        .OPTN_NUM_MASTERS   (N),
        .OPTN_WB_DATA_WIDTH (DW),
        .OPTN_WB_ADDR_WIDTH (AW)
    ) dut (
        .i_wb_clk  (clk),
        .i_wb_rst  (rst),
        .i_wb_cyc  (wb_cyc),
        .i_wb_stb  (wb_stb),
        .i_wb_we   (wb_we),
        .i_wb_cti  (wb_cti),
        .i_wb_bte  (wb_bte),
        .i_wb_sel  (wb_sel),
        .i_wb_addr (wb_addr),
        .i_wb_data (wb_data),
        .o_wb_ack  (wb_ack),
        .o_wb_data (wb_rdata),
        .o_sl_cyc  (sl_cyc),
        .o_sl_stb  (sl_stb),
        .o_sl_we   (sl_we),
        .o_sl_cti  (sl_cti),
        .o_sl_bte  (sl_bte),
        .o_sl_sel  (sl_sel),
        .o_sl_addr (sl_addr),
        .o_sl_data (sl_wdata),
        .i_sl_ack  (sl_ack),
        .i_sl_data (sl_rdata),
        .o_grant   (grant)
    );

    // ---------------- slave model ----------------
    logic ack_q, force_ack;
    assign sl_ack = ack_q | force_ack;

    function automatic logic [DW-1:0] slave_rd(input logic [AW-1:0] a);
        if (a == 32'h10) return 16'hBEEF;
        return a[15:0] ^ 16'h1234;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q    <= 1'b0;
            sl_rdata <= 16'h0000;
        end else begin
            ack_q    <= sl_cyc & sl_stb & ~ack_q;
            sl_rdata <= slave_rd(sl_addr);
        end
    end

    // ---------------- scoreboard ----------------
    int   vectors = 0;
    int   errors  = 0;
    exp_t sbq0[$];
    exp_t sbq1[$];
    int   ack_log[$];
    exp_t mon_e;
    int   mon_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && wb_ack != '0) begin
            vectors++;
            if (!$onehot(wb_ack)) begin
                errors++;
                $display("FAIL ack_onehot: got ack %b, required one-hot", wb_ack);
            end else begin
                mon_m = wb_ack[1] ? 1 : 0;
                ack_log.push_back(mon_m);
                if ((mon_m == 0 && sbq0.size() == 0) || (mon_m == 1 && sbq1.size() == 0)) begin
                    errors++;
                    $display("FAIL foreign_ack: got ack %b, required no ack for master %0d", wb_ack, mon_m);
                end else begin
                    mon_e = (mon_m == 0) ? sbq0.pop_front() : sbq1.pop_front();
                    if (sl_addr !== mon_e.addr) begin
                        errors++;
                        $display("FAIL ack_addr m%0d: got 0x%0h, required 0x%0h", mon_m, sl_addr, mon_e.addr);
                    end else if (mon_e.we && sl_wdata !== mon_e.data) begin
                        errors++;
                        $display("FAIL wr_data m%0d: got 0x%0h, required 0x%0h", mon_m, sl_wdata, mon_e.data);
                    end else if (!mon_e.we && wb_rdata !== mon_e.data) begin
                        errors++;
                        $display("FAIL rd_data m%0d: got 0x%0h, required 0x%0h", mon_m, wb_rdata, mon_e.data);
                    end
                end
            end
        end
    end

    // ---------------- master driver ----------------
    // Call just after a rising edge. d is write data or the expected read data.
    task automatic do_xfer(input int m, input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] d, input logic [2:0] cti, input logic drop);
        exp_t e;
        int   n;
        e.we = we; e.addr = addr; e.data = d;
        if (m == 0) sbq0.push_back(e); else sbq1.push_back(e);
        m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we;
        m_addr[m] = addr; m_cti[m] = cti; m_data[m] = we ? d : 16'h0000;
        n = 0;
        @(negedge clk);
        while (!wb_ack[m] && n < 60) begin
            n++;
            @(negedge clk);
        end
        if (!wb_ack[m]) begin
            vectors++;
            errors++;
            $display("FAIL timeout m%0d addr 0x%0h: no ack after %0d cycles, ack required", m, addr, n);
            if (m == 0) void'(sbq0.pop_back()); else void'(sbq1.pop_back());
        end
        @(posedge clk);
        #1;
        if (drop) begin
            m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
        end
    endtask

    task automatic wait_ack1();
        int n;
        n = 0;
        @(negedge clk);
        while (!wb_ack[1] && n < 30) begin
            n++;
            @(negedge clk);
        end
        chk("burst_first_ack", {31'd0, wb_ack[1]}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    int exp_order3[4];
    int exp_order4[5] = '{1, 1, 1, 1, 0};

    initial begin
        for (int i = 0; i < N; i++) begin
            m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
            m_cti[i] = 3'b000; m_addr[i] = '0; m_data[i] = '0;
        end
        force_ack = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_sl_cyc", {31'd0, sl_cyc}, 32'd0);
        chk("rst_sl_stb", {31'd0, sl_stb}, 32'd0);
        chk("rst_sl_we", {31'd0, sl_we}, 32'd0);
        chk("rst_sl_sel", {30'd0, sl_sel}, 32'd0);
        chk("rst_sl_addr", sl_addr, 32'd0);
        chk("rst_sl_cti", {29'd0, sl_cti}, 32'd7);
        chk("rst_wb_ack", {30'd0, wb_ack}, 32'd0);
        chk("rst_rdata_follow", {16'd0, wb_rdata}, {16'd0, sl_rdata});
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Single classic read from master 1
        fork
            do_xfer(1, 1'b0, 32'h10, 16'hBEEF, 3'b000, 1'b1);
            begin
                @(negedge clk); chk("t1_idle_grant", {30'd0, grant}, 32'd0);
                @(negedge clk); chk("t1_grant", {30'd0, grant}, 32'd2);
                chk("t1_cti_rewrite", {29'd0, sl_cti}, 32'd7);
                chk("t1_sl_cyc", {31'd0, sl_cyc}, 32'd1);
                chk("t1_sl_addr", sl_addr, 32'h10);
                @(negedge clk); chk("t1_ack", {30'd0, wb_ack}, 32'd2);
                @(negedge clk); chk("t1_back_idle", {30'd0, grant}, 32'd0);
            end
        join
        @(posedge clk); #1;
        pulse_reset();

        // Both masters request together
        fork
            do_xfer(0, 1'b0, 32'h20, 16'h1214, 3'b000, 1'b1);
            do_xfer(1, 1'b0, 32'h30, 16'h1204, 3'b000, 1'b1);
            begin
                @(negedge clk);
                @(negedge clk); chk("t2_first_grant", {30'd0, grant}, 32'd1);
                @(negedge clk); chk("t2_ack0", {30'd0, wb_ack}, 32'd1);
                @(negedge clk); chk("t2_gap_idle", {30'd0, grant}, 32'd0);
                @(negedge clk); chk("t2_second_grant", {30'd0, grant}, 32'd2);
            end
        join
        @(posedge clk); #1;
        pulse_reset();

        // Master 0 re-requests continuously while master 1 waits
`ifdef WB_ARB_ROUND_ROBIN_EN
        exp_order3 = '{0, 1, 0, 0};
`else
        exp_order3 = '{0, 0, 0, 1};
`endif
        ack_log.delete();
        fork
            begin
                do_xfer(0, 1'b0, 32'h20, 16'h1214, 3'b000, 1'b0);
                do_xfer(0, 1'b0, 32'h40, 16'h1274, 3'b000, 1'b0);
                do_xfer(0, 1'b0, 32'h50, 16'h1264, 3'b000, 1'b1);
            end
            do_xfer(1, 1'b0, 32'h30, 16'h1204, 3'b000, 1'b1);
        join
        chk("t3_ack_count", ack_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < ack_log.size(); i++)
            chk($sformatf("t3_order_%0d", i), ack_log[i], exp_order3[i]);
        @(posedge clk); #1;

        // 4-beat incrementing write burst from master 1, master 0 queued behind
        ack_log.delete();
        fork
            begin
                do_xfer(1, 1'b1, 32'h100, 16'hA001, 3'b010, 1'b0);
                do_xfer(1, 1'b1, 32'h102, 16'hA002, 3'b010, 1'b0);
                do_xfer(1, 1'b1, 32'h104, 16'hA003, 3'b010, 1'b0);
                do_xfer(1, 1'b1, 32'h106, 16'hA004, 3'b111, 1'b1);
            end
            begin
                @(posedge clk); #1;
                do_xfer(0, 1'b0, 32'h40, 16'h1274, 3'b101, 1'b1);
            end
            begin
                @(negedge clk);
                @(negedge clk); chk("t4_incr_cti", {29'd0, sl_cti}, 32'd2);
                chk("t4_burst_grant", {30'd0, grant}, 32'd2);
                chk("t4_sl_we", {31'd0, sl_we}, 32'd1);
            end
        join
        @(negedge clk); chk("t4_unsupported_cti_ends", {30'd0, grant}, 32'd0);
        chk("t4_ack_count", ack_log.size(), 32'd5);
        for (int i = 0; i < 5 && i < ack_log.size(); i++)
            chk($sformatf("t4_order_%0d", i), ack_log[i], exp_order4[i]);
        @(posedge clk); #1;

        // Owner abandons burst, slave never acks: three flush cycles
        fork
            do_xfer(1, 1'b0, 32'h200, 16'h1034, 3'b010, 1'b1);
            begin
                wait_ack1();
                fork
                    do_xfer(0, 1'b0, 32'h50, 16'h1264, 3'b000, 1'b1);
                    begin
                        @(negedge clk); chk("t5_drop_sl_cyc", {31'd0, sl_cyc}, 32'd0);
                        @(negedge clk); chk("t5_f1_sl_cyc", {31'd0, sl_cyc}, 32'd0);
                        chk("t5_f1_cti", {29'd0, sl_cti}, 32'd7);
                        chk("t5_f1_sel", {30'd0, sl_sel}, 32'd0);
                        chk("t5_f1_grant0", {31'd0, grant[0]}, 32'd0);
                        @(negedge clk); chk("t5_f2_grant0", {31'd0, grant[0]}, 32'd0);
                        @(negedge clk); chk("t5_f3_grant0", {31'd0, grant[0]}, 32'd0);
                        @(negedge clk); chk("t5_idle", {30'd0, grant}, 32'd0);
                        @(negedge clk); chk("t5_after_flush", {30'd0, grant}, 32'd1);
                    end
                join
            end
        join
        @(posedge clk); #1;

        // Owner abandons burst, slave acks in the first flush cycle
        fork
            do_xfer(1, 1'b0, 32'h300, 16'h1134, 3'b010, 1'b1);
            begin
                wait_ack1();
                fork
                    do_xfer(0, 1'b0, 32'h60, 16'h1254, 3'b000, 1'b1);
                    begin
                        @(negedge clk);
                        @(posedge clk); #1 force_ack = 1'b1;
                        @(negedge clk); chk("t5b_flush_no_ack", {30'd0, wb_ack}, 32'd0);
                        @(posedge clk); #1 force_ack = 1'b0;
                        @(negedge clk); chk("t5b_idle", {30'd0, grant}, 32'd0);
                        @(negedge clk); chk("t5b_early_exit", {30'd0, grant}, 32'd1);
                    end
                join
            end
        join
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a burst
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0;
        m_cti[1] = 3'b010; m_addr[1] = 32'h400;
        @(negedge clk);
        @(negedge clk); chk("t6_granted", {30'd0, grant}, 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_grant", {30'd0, grant}, 32'd0);
        chk("t6_async_sl_cyc", {31'd0, sl_cyc}, 32'd0);
        chk("t6_async_ack", {30'd0, wb_ack}, 32'd0);
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_post_cti", {29'd0, sl_cti}, 32'd7);
        @(posedge clk); #1;
        fork
            do_xfer(0, 1'b0, 32'h60, 16'h1254, 3'b000, 1'b1);
            begin
                @(negedge clk); chk("t6_req_idle", {30'd0, grant}, 32'd0);
                @(negedge clk); chk("t6_latency", {30'd0, grant}, 32'd1);
            end
        join
        @(posedge clk); #1;

        chk("sb_drained", sbq0.size() + sbq1.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000ns");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_sram_arbiter.md
# wb_sram_arbiter

Wishbone B4 N-to-1 arbiter that shares the single `sram_wb` SRAM controller slave among several bus masters (e.g. instruction fetch, data port, debug/loader). It grants the slave port to one master for a whole transfer (classic cycle or incrementing burst) and releases it only once the slave is back in its idle state. It also rewrites CTI so that the slave always terminates. It sits between the masters' Wishbone ports and the SRAM controller's slave port.

## Interface
Parameters:
- `OPTN_NUM_MASTERS`, 2: number of requesters, 2..8.
- `OPTN_WB_DATA_WIDTH`, 16: data width; must match the SRAM controller (16/32/64).
- `OPTN_WB_ADDR_WIDTH`, 32: address width.
- `WB_DATA_SIZE`, `OPTN_WB_DATA_WIDTH/8`: byte-select width (derived).

Ports (N = `OPTN_NUM_MASTERS`):
- `i_wb_clk`  in  1  clock.
- `i_wb_rst`  in  1  reset, asynchronous, active-high.
- `i_wb_cyc`, `i_wb_stb`, `i_wb_we`  in  N each  per-master cycle/strobe/write.
- `i_wb_cti`  in  N*3  per-master CTI.
- `i_wb_bte`  in  N*2  per-master BTE.
- `i_wb_sel`  in  N*WB_DATA_SIZE  per-master byte selects.
- `i_wb_addr`  in  N*OPTN_WB_ADDR_WIDTH  per-master address.
- `i_wb_data`  in  N*OPTN_WB_DATA_WIDTH  per-master write data.
- `o_wb_ack`  out  N  per-master ack.
- `o_wb_data`  out  OPTN_WB_DATA_WIDTH  read data, broadcast to all masters.
- `o_sl_cyc`, `o_sl_stb`, `o_sl_we`  out  1 each  slave-side controls.
- `o_sl_cti`  out  3  slave-side CTI.
- `o_sl_bte`  out  2  slave-side BTE.
- `o_sl_sel`, `o_sl_addr`, `o_sl_data`  out  widths as above  slave-side select/address/write data.
- `i_sl_ack`  in  1  slave ack.
- `i_sl_data`  in  OPTN_WB_DATA_WIDTH  slave read data.
- `o_grant`  out  N  one-hot current owner; 0 when none.

## Operation
- FSM states:
  - IDLE: no owner.
  - GRANT: owner's signals forwarded.
  - FLUSH: owner dropped `cyc` before end of burst.
- IDLE:
  - Request vector is `i_wb_cyc & i_wb_stb`.
  - If the vector is non-zero, register the winner into `o_grant` and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - Slave port outputs are the granted master's signals, muxed by `o_grant`.
  - `o_sl_cyc` and `o_sl_stb` are the owner's values.
  - `o_wb_ack[g] = i_sl_ack`; every other ack bit is 0.
  - `o_wb_data = i_sl_data` at all times.
- CTI rewrite: owner CTI CLASSIC (000) or any unsupported code (001, 011..110) is driven to the slave as END_OF_BURST (111). INCREMENTING (010) and END_OF_BURST pass through unchanged.
- GRANT → IDLE when `i_sl_ack` is high and `o_sl_cti` is END_OF_BURST. `o_grant` is cleared on that edge.
- GRANT → FLUSH when the owner's `i_wb_cyc` is low.
- FLUSH:
  - `o_sl_cyc` = `o_sl_stb` = `o_sl_we` = 0, `o_sl_sel` = 0, `o_sl_cti` = 111.
  - Acks are not forwarded.
  - 2-bit counter, loaded with 3 on entry.
  - Exit to IDLE on `i_sl_ack` or when the counter reaches 0, whichever is first, so the slave drains its gather/ack states.
- No re-arbitration while in GRANT or FLUSH. An IDLE cycle always separates two grants.
- Masters that are not granted see ack 0 and must hold their request.

## Timing
- Request high at edge k in IDLE → `o_grant` and slave signals valid in cycle k+1. Arbitration latency is 1 cycle.
- All slave-side outputs and `o_wb_ack` are combinational from `o_grant`/state and the live inputs. This adds 0 cycles to the slave's own latency.
- Final ack of a transfer at edge j → IDLE at j+1 → earliest next grant at j+2.
- Reset values:
  - State IDLE, `o_grant` = 0, round-robin pointer = 0, FLUSH counter = 0.
  - All `o_sl_*` = 0, except `o_sl_cti` = 111.
  - `o_wb_ack` = 0.
  - `o_wb_data` follows `i_sl_data`.
- Reset asserted mid-transfer: grant is dropped immediately (asynchronous). The slave is reset by the same `i_wb_rst`.
- Simultaneous `i_sl_ack` with EOB and owner `cyc` low: IDLE takes precedence over FLUSH.

## Configuration
- Macro `WB_ARB_ROUND_ROBIN_EN`.
- Defined: round-robin.
  - Search for the winner starts at pointer p and wraps modulo N.
  - On each grant, p ← winner+1, wrapping to 0 after N-1.
- Undefined: fixed priority, lowest index wins. The pointer register is not instantiated.

## Structure
- Shared package `wb_pkg`:
  - CTI/BTE width and code constants (CLASSIC, CONSTANT, INCREMENTING, END_OF_BURST, LINEAR, 4/8/16-beat).
  - Arbiter state enum `wb_arb_state_t`.
  - These replace the per-file defines.
- Sub-module `wb_arb_pick`: purely combinational N-way one-hot picker. Inputs are the request vector and the start pointer; output is the one-hot winner. Fixed priority uses a pointer of 0.

## Test plan
- Single classic read, N=2, master 1 only, addr 0x10 → `o_grant` = 2'b10 one cycle after request; `o_sl_cti` = 111; `o_wb_ack[1]` high once, data 0xBEEF; back to IDLE after the ack.
- Both masters request in the same cycle after reset, round-robin → master 0 granted first. Master 1 is granted at the ack-edge+2 and neither master ever sees a foreign ack.
- Same stimulus without `WB_ARB_ROUND_ROBIN_EN`, master 0 re-requesting continuously → master 1 never granted (starvation is expected).
- 4-beat incrementing write burst from master 1, then EOB, while master 0 requests → grant is held for all 4 acks and master 0 is granted only after the EOB ack.
- Owner drops `cyc` mid-burst → FLUSH with `o_sl_cyc` = 0 and `o_sl_cti` = 111. Exit on the first slave ack, or after 3 cycles with no ack.
- Asynchronous reset pulse mid-burst → `o_grant` = 0, `o_sl_cyc` = 0 and `o_wb_ack` = 0 immediately. After release the next request is granted with 1-cycle latency.
